// File: rtl/mlp_scheduler_pkg.sv
// Shared constants, FSM state and class encodings, and fixed-point helpers for the MLP scheduler.
// Optional y_raw output is enabled by defining MLP_YRAW_EN.
package mlp_scheduler_pkg;

  localparam int FRAC_W = 8;
  localparam int ACC_W  = 48;

  localparam logic signed [ACC_W-1:0] ONE = 48'sh0000_0001_0000;
  localparam logic signed [ACC_W-1:0] TH3 = 48'sh0000_0000_9999;
  localparam logic signed [ACC_W-1:0] TH2 = 48'sh0000_0000_8000;
  localparam logic signed [ACC_W-1:0] TH1 = 48'sh0000_0000_6666;
  localparam logic signed [ACC_W-1:0] S32_MAX = 48'sh0000_7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] S32_MIN = -48'sh0000_8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HID_ISSUE,
    S_HID_ACT,
    S_OUT_ISSUE,
    S_OUT_ACT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_0,
    CLS_1,
    CLS_2,
    CLS_3
  } class_t;

  // Hidden activation: ReLU with an upper rail at 1.0.
  function automatic logic [31:0] clamp_unit(input logic signed [ACC_W-1:0] v);
    if (v < 0) return '0;
    if (v > ONE) return ONE[31:0];
    return v[31:0];
  endfunction

  function automatic class_t classify(input logic signed [ACC_W-1:0] y);
    if (y > TH3) return CLS_3;
    if (y > TH2) return CLS_2;
    if (y > TH1) return CLS_1;
    return CLS_0;
  endfunction

  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
    if (v > S32_MAX) return 32'h7FFF_FFFF;
    if (v < S32_MIN) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/mlp_scheduler_if.sv
// Request/result and weight-ROM signals of the MLP scheduler, bundled with slave (scheduler) and master views.
// y_raw exists only when MLP_YRAW_EN is defined.
interface mlp_scheduler_if #(
  parameter int N_IN = 6,
  parameter int AW   = 7
);
  logic                 start;
  logic [32*N_IN-1:0]   features;
  logic                 busy;
  logic                 done;
  logic [1:0]           result;
  logic                 w_rd;
  logic [AW-1:0]        w_addr;
  logic [15:0]          w_data;
`ifdef MLP_YRAW_EN
  logic [31:0]          y_raw;

  modport slave  (input start, features, w_data,
                  output busy, done, result, w_rd, w_addr, y_raw);
  modport master (output start, features, w_data,
                  input busy, done, result, w_rd, w_addr, y_raw);
`else
  modport slave  (input start, features, w_data,
                  output busy, done, result, w_rd, w_addr);
  modport master (output start, features, w_data,
                  input busy, done, result, w_rd, w_addr);
`endif
endinterface

// File: rtl/mlp_mac.sv
// Shared multiply-accumulate: Q16.16 x Q8.8 -> Q16.16 term, or a Q8.8 bias promoted to Q16.16,
// added into a 48-bit signed accumulator; sum is the combinational next value.
module mlp_mac
  import mlp_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    bias_sel,
  input  logic [31:0]             x,
  input  logic signed [15:0]      w,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [48:0]      prod;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] acc;

  always_comb begin
    // x is unsigned, so a zero sign bit keeps it positive in the signed product.
    prod = $signed({1'b0, x}) * w;
    term = ACC_W'(prod >>> FRAC_W);
    bias = {{(ACC_W-16-FRAC_W){w[15]}}, w, {FRAC_W{1'b0}}};
    sum  = acc + (bias_sel ? bias : term);
  end

  always_ff @(posedge clk) begin
    if (!clear || clr) acc <= '0;
    else if (en)       acc <= sum;
  end

endmodule

// File: rtl/mlp_scheduler.sv
// Sequences MLP inference (N_IN inputs, N_HID clamped hidden neurons, one output) on one MAC,
// fetching weights from a 1-cycle ROM. Defining MLP_YRAW_EN adds the saturated y_raw output.
module mlp_scheduler
  import mlp_scheduler_pkg::*;
#(
  parameter int N_IN  = 6,
  parameter int N_HID = 7,
  parameter int AW    = 7
) (
  input logic            ADC_CLK_10,
  input logic            clear,
  mlp_scheduler_if.slave bus
);

  localparam int CNT_MAX = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int J_W     = (N_HID > 1) ? $clog2(N_HID) : 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [J_W-1:0]    j_q, j_d;
  logic [AW-1:0]     addr_q, addr_d;
  class_t            result_q;
  logic [31:0]       feat_q [N_IN];
  logic [31:0]       h_q    [N_HID];

  logic              w_rd, load, store_h, store_y;
  logic              mac_en, mac_clr, bias_sel;
  logic [31:0]       mac_x;
  logic signed [ACC_W-1:0] mac_sum;

  // NOTE: every signal is defaulted before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    j_d      = j_q;
    addr_d   = addr_q;
    w_rd     = 1'b0;
    load     = 1'b0;
    store_h  = 1'b0;
    store_y  = 1'b0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    bias_sel = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        state_d = S_HID_ISSUE;
        cnt_d   = '0;
        j_d     = '0;
        addr_d  = '0;
        load    = 1'b1;
      end
      S_HID_ISSUE: begin
        // Data for the address issued last cycle arrives now; cycle 0 has nothing to add yet.
        w_rd   = 1'b1;
        mac_en = (cnt_q != '0);
        addr_d = addr_q + AW'(1);
        if (cnt_q == CNT_W'(N_IN)) begin
          state_d = S_HID_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HID_ACT: begin
        bias_sel = 1'b1;
        mac_clr  = 1'b1;
        store_h  = 1'b1;
        if (j_q == J_W'(N_HID - 1)) begin
          state_d = S_OUT_ISSUE;
          j_d     = '0;
        end else begin
          state_d = S_HID_ISSUE;
          j_d     = j_q + J_W'(1);
        end
      end
      S_OUT_ISSUE: begin
        w_rd   = 1'b1;
        mac_en = (cnt_q != '0);
        addr_d = addr_q + AW'(1);
        if (cnt_q == CNT_W'(N_HID)) begin
          state_d = S_OUT_ACT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_OUT_ACT: begin
        bias_sel = 1'b1;
        mac_clr  = 1'b1;
        store_y  = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand select: the term arriving at count c belongs to input c-1.
  always_comb begin
    mac_x = '0;
    if (state_q == S_HID_ISSUE) begin
      for (int k = 0; k < N_IN; k++)
        if (cnt_q == CNT_W'(k + 1)) mac_x = feat_q[k];
    end else if (state_q == S_OUT_ISSUE) begin
      for (int k = 0; k < N_HID; k++)
        if (cnt_q == CNT_W'(k + 1)) mac_x = h_q[k];
    end
  end

  mlp_mac u_mac (
    .clk      (ADC_CLK_10),
    .clear    (clear),
    .clr      (mac_clr),
    .en       (mac_en),
    .bias_sel (bias_sel),
    .x        (mac_x),
    .w        ($signed(bus.w_data)),
    .sum      (mac_sum)
  );

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the hidden register file is reset because a run must start from cleared state;
  // the feature latch is not, as it is always written on start before being read.
  always_ff @(posedge ADC_CLK_10) begin
    if (!clear) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      j_q      <= '0;
      addr_q   <= '0;
      result_q <= CLS_0;
      for (int k = 0; k < N_HID; k++) h_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      if (store_h)
        for (int k = 0; k < N_HID; k++)
          if (j_q == J_W'(k)) h_q[k] <= clamp_unit(mac_sum);
      if (store_y) result_q <= classify(mac_sum);
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (load)
      for (int k = 0; k < N_IN; k++) feat_q[k] <= bus.features[32*k +: 32];
  end

`ifdef MLP_YRAW_EN
  logic [31:0] y_raw_q;

  always_ff @(posedge ADC_CLK_10) begin
    if (!clear)       y_raw_q <= '0;
    else if (store_y) y_raw_q <= sat32(mac_sum);
  end

  assign bus.y_raw = y_raw_q;
`endif

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.w_rd   = w_rd;
  assign bus.w_addr = w_rd ? addr_q : '0;

endmodule

// File: tb/tb_mlp_scheduler.sv
// Scoreboard bench for mlp_scheduler: directed ROM/feature vectors with hand-computed classes.
// Also checks y_raw when MLP_YRAW_EN is defined.
module tb_mlp_scheduler;

  localparam int N_IN  = 6;
  localparam int N_HID = 7;
  localparam int AW    = 7;
  localparam int HB    = N_HID * (N_IN + 1);
  localparam int HCYC  = N_HID * (N_IN + 2);
  localparam int LAT   = 1 + HCYC + (N_HID + 2);

  typedef struct {
    logic [1:0]  res;
    logic [31:0] y;
    int          t0;
  } exp_t;

  logic ADC_CLK_10 = 1'b0;
  logic clear;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   done_cnt = 0;
  int   runs = 0;
  logic chk_idle = 1'b0;
  exp_t sb_q [$];
  logic [15:0] rom [0:(1<<AW)-1];

  mlp_scheduler_if #(.N_IN(N_IN), .AW(AW)) bus ();

  mlp_scheduler #(.N_IN(N_IN), .N_HID(N_HID), .AW(AW)) dut (
    .ADC_CLK_10 (ADC_CLK_10),
    .clear      (clear),
    .bus        (bus)
  );

  always #5 ADC_CLK_10 = ~ADC_CLK_10;
  always @(posedge ADC_CLK_10) cyc <= cyc + 1;

  // One-cycle ROM; a poison value when not read exposes use of unrequested data.
  always @(posedge ADC_CLK_10) bus.w_data <= bus.w_rd ? rom[bus.w_addr] : 16'hBEEF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge ADC_CLK_10) begin
    exp_t e;
    if (chk_idle) begin
      check("busy_after_done", 64'(bus.busy), 64'd0);
      check("done_one_cycle", 64'(bus.done), 64'd0);
    end
    chk_idle = bus.done;
    if (bus.done) begin
      check("done_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("latency", 64'(cyc - e.t0), 64'(LAT));
`ifdef MLP_YRAW_EN
        check("y_raw", 64'(bus.y_raw), 64'(e.y));
`endif
      end
      done_cnt++;
    end
  end

  task automatic fill_rom(input logic [15:0] hw, input logic [15:0] hb,
                          input logic [15:0] ow, input logic [15:0] ob);
    for (int a = 0; a < (1 << AW); a++) rom[a] = 16'h0000;
    for (int j = 0; j < N_HID; j++) begin
      for (int i = 0; i < N_IN; i++) rom[j*(N_IN+1)+i] = hw;
      rom[j*(N_IN+1)+N_IN] = hb;
      rom[HB+j] = ow;
    end
    rom[HB+N_HID] = ob;
  endtask

  task automatic set_features(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] rest);
    for (int i = 0; i < N_IN; i++) bus.features[32*i +: 32] = rest;
    bus.features[31:0]  = x0;
    bus.features[63:32] = x1;
  endtask

  // Drives start for one cycle; returns at the next negedge (cycle 1 of the run).
  task automatic launch(input logic [1:0] res, input logic [31:0] y, output int t0);
    @(negedge ADC_CLK_10);
    bus.start = 1'b1;
    t0 = cyc;
    sb_q.push_back('{res: res, y: y, t0: cyc});
    runs++;
    @(negedge ADC_CLK_10);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt < runs && n < 200) begin
      @(negedge ADC_CLK_10);
      n++;
    end
    check("done_seen", 64'(done_cnt), 64'(runs));
    repeat (3) @(negedge ADC_CLK_10);
  endtask

  task automatic pulse_start_at(input int t);
    while (cyc < t) @(negedge ADC_CLK_10);
    bus.start = 1'b1;
    @(negedge ADC_CLK_10);
    bus.start = 1'b0;
  endtask

  task automatic trace_run(input int t0);
    int bad = 0;
    int p;
    logic exp_rd;
    logic [AW-1:0] exp_addr;
    for (int t = 1; t <= LAT; t++) begin
      if (t <= HCYC) begin
        p        = (t - 1) % (N_IN + 2);
        exp_rd   = (p <= N_IN);
        exp_addr = exp_rd ? AW'(((t - 1) / (N_IN + 2)) * (N_IN + 1) + p) : '0;
      end else if (t <= HCYC + N_HID + 1) begin
        exp_rd   = 1'b1;
        exp_addr = AW'(HB + t - HCYC - 1);
      end else begin
        exp_rd   = 1'b0;
        exp_addr = '0;
      end
      if (cyc - t0 != t || bus.w_rd !== exp_rd || bus.w_addr !== exp_addr || bus.busy !== 1'b1)
        bad++;
      if (t < LAT) @(negedge ADC_CLK_10);
    end
    check("addr_trace_bad_cycles", 64'(bad), 64'd0);
  endtask

  initial begin
    int t0;
    clear     = 1'b0;
    bus.start = 1'b1;
    set_features(32'h0003_0000, 32'h0000_8000, 32'h0001_2345);
    fill_rom(16'h0000, 16'h0000, 16'h0000, 16'h0000);

    // Reset held 2 cycles with start asserted: reset must win.
    repeat (2) @(negedge ADC_CLK_10);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_w_rd", 64'(bus.w_rd), 64'd0);
    check("rst_w_addr", 64'(bus.w_addr), 64'd0);
    clear     = 1'b1;
    bus.start = 1'b0;
    @(negedge ADC_CLK_10);
    check("busy_after_reset_start", 64'(bus.busy), 64'd0);

    // All-zero ROM, with full address trace.
    launch(2'd0, 32'h0000_0000, t0);
    trace_run(t0);
    wait_done();

    // h = 1.0 each, 7 * 0.125 -> y = 0xE000.
    fill_rom(16'h0000, 16'h0100, 16'h0020, 16'h0000);
    launch(2'd3, 32'h0000_E000, t0);
    wait_done();

    // h clamps to 0, y = 0x8000 exactly: not above TH2.
    fill_rom(16'h0000, 16'hFF00, 16'h0020, 16'h0080);
    launch(2'd1, 32'h0000_8000, t0);
    wait_done();

    // h = 1.5*0.5 - 1.0*0.25 = 0x8000; y = 7 * (0.5 * 0x26/256) = 0x8500.
    fill_rom(16'h0000, 16'h0000, 16'h0026, 16'h0000);
    for (int j = 0; j < N_HID; j++) begin
      rom[j*(N_IN+1)+0] = 16'h0080;
      rom[j*(N_IN+1)+1] = 16'hFFC0;
    end
    set_features(32'h0001_8000, 32'h0001_0000, 32'h0005_0000);
    launch(2'd2, 32'h0000_8500, t0);
    wait_done();

    // Negative output bias only: y = -1.0.
    fill_rom(16'h0000, 16'h0000, 16'h0000, 16'hFF00);
    launch(2'd0, 32'hFFFF_0000, t0);
    wait_done();

    // Start pulses mid-run are ignored and not queued.
    fill_rom(16'h0000, 16'h0100, 16'h0020, 16'h0000);
    launch(2'd3, 32'h0000_E000, t0);
    pulse_start_at(t0 + 10);
    pulse_start_at(t0 + 40);
    wait_done();
    repeat (80) @(negedge ADC_CLK_10);

    // Abort at cycle 30: no done, outputs back to reset values.
    @(negedge ADC_CLK_10);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge ADC_CLK_10);
    bus.start = 1'b0;
    while (cyc < t0 + 30) @(negedge ADC_CLK_10);
    clear = 1'b0;
    @(negedge ADC_CLK_10);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    check("abort_w_rd", 64'(bus.w_rd), 64'd0);
    clear = 1'b1;
    repeat (80) @(negedge ADC_CLK_10);

    // Fresh run after the abort.
    fill_rom(16'h0000, 16'h0000, 16'h0026, 16'h0000);
    for (int j = 0; j < N_HID; j++) begin
      rom[j*(N_IN+1)+0] = 16'h0080;
      rom[j*(N_IN+1)+1] = 16'hFFC0;
    end
    launch(2'd2, 32'h0000_8500, t0);
    wait_done();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
